// File: rtl/reflet_reset_sequencer.sv
// -----------------------------------------------------------------------------
// reflet_reset_sequencer
// Turns the power-on/external reset, a bouncy push-button and a software
// request into staged reset outputs. Peripherals are released HOLD_CYCLES
// edges after the last reset event, and the CPU STAGE_GAP edges later. The
// cause of the last reset is reported.
//
// Ports:
//   clk             system clock
//   reset           asynchronous active-high reset (power-on pulse / external)
//   button_in       raw push-button, active-high, asynchronous, bouncy
//   sw_reset_req    synchronous software reset request, active-high
//   periph_reset    active-high peripheral reset (registered)
//   cpu_reset       active-high CPU reset (registered)
//   sequencer_ready high once both resets are released (registered)
//   reset_cause     00 power/external, 01 button, 10 software (registered)
// -----------------------------------------------------------------------------
module reflet_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned STAGE_GAP       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_in,
    input  logic       sw_reset_req,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       sequencer_ready,
    output logic [1:0] reset_cause
);

    localparam int unsigned SEQ_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    // Terminal counts: the transition happens on the edge that would reach the full count.
    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(STAGE_GAP - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CAUSE_POWER  = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SW     = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_GAP  = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t            r_state;
    logic [SEQ_W-1:0]  r_seq_cnt;
    logic              r_periph_reset;
    logic              r_cpu_reset;
    logic              r_ready;
    logic [1:0]        r_cause;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic              r_db_prev;
    logic [DB_W-1:0]   r_db_cnt;

    logic              w_button_event;
    logic              w_request;

    // Button synchronizer, debouncer and edge-detect register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= button_in;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                // Disagreement persisted long enough: accept the new level.
                r_db_level <= ~r_db_level;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Only a rising debounced level is an event; holding or releasing does nothing.
    assign w_button_event = r_db_level & ~r_db_prev;
    assign w_request      = w_button_event | sw_reset_req;

    // Reset sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_HOLD;
            r_seq_cnt      <= '0;
            r_periph_reset <= 1'b1;
            r_cpu_reset    <= 1'b1;
            r_ready        <= 1'b0;
            r_cause        <= CAUSE_POWER;
        end else if (w_request) begin
            // Any request restarts the whole sequence; the button wins a tie.
            r_state        <= ST_HOLD;
            r_seq_cnt      <= '0;
            r_periph_reset <= 1'b1;
            r_cpu_reset    <= 1'b1;
            r_ready        <= 1'b0;
            r_cause        <= w_button_event ? CAUSE_BUTTON : CAUSE_SW;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_seq_cnt == HOLD_LAST) begin
                        r_state        <= ST_GAP;
                        r_seq_cnt      <= '0;
                        r_periph_reset <= 1'b0;
                    end else begin
                        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_seq_cnt == GAP_LAST) begin
                        r_state     <= ST_RUN;
                        r_seq_cnt   <= '0;
                        r_cpu_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
                    end
                end
                ST_RUN: begin
                    r_seq_cnt <= '0;
                end
                default: begin
                    // Unreachable encoding: fall back into a full hold.
                    r_state        <= ST_HOLD;
                    r_seq_cnt      <= '0;
                    r_periph_reset <= 1'b1;
                    r_cpu_reset    <= 1'b1;
                    r_ready        <= 1'b0;
                end
            endcase
        end
    end

    assign periph_reset    = r_periph_reset;
    assign cpu_reset       = r_cpu_reset;
    assign sequencer_ready = r_ready;
    assign reset_cause     = r_cause;

endmodule

// File: tb/tb_reflet_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for reflet_reset_sequencer. A reference model tracks the number
// of edges since the last reset event and the button's accepted level, and
// pushes the expected outputs for every edge (and every async reset
// assertion) into a queue; a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_reflet_reset_sequencer;

    localparam int unsigned HC = 16;
    localparam int unsigned SG = 4;
    localparam int unsigned DC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_in;
    logic       sw_reset_req;
    logic       periph_reset;
    logic       cpu_reset;
    logic       sequencer_ready;
    logic [1:0] reset_cause;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];

    reflet_reset_sequencer #(
        .HOLD_CYCLES    (HC),
        .STAGE_GAP      (SG),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .button_in      (button_in),
        .sw_reset_req   (sw_reset_req),
        .periph_reset   (periph_reset),
        .cpu_reset      (cpu_reset),
        .sequencer_ready(sequencer_ready),
        .reset_cause    (reset_cause)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int         m_since;    // edges since the sequence was (re)started
    logic [1:0] m_cause;
    logic       m_level;    // accepted button level
    int         m_run;      // consecutive edges the seen button disagreed with m_level
    logic       m_pending;  // accepted level rose on the previous edge
    logic       m_hist0;    // button_in sampled one edge ago
    logic       m_hist1;    // button_in sampled two edges ago
    logic       m_seen;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_since   = 0;
            m_cause   = 2'b00;
            m_level   = 1'b0;
            m_run     = 0;
            m_pending = 1'b0;
            m_hist0   = 1'b0;
            m_hist1   = 1'b0;
        end else begin
            // The debouncer sees the button as it was two edges ago.
            m_seen = m_hist1;
            if (m_pending || sw_reset_req) begin
                m_since = 0;
                m_cause = m_pending ? 2'b01 : 2'b10;
            end else if (m_since < int'(HC + SG)) begin
                m_since = m_since + 1;
            end
            m_pending = 1'b0;
            if (m_seen != m_level) begin
                m_run = m_run + 1;
                if (m_run == int'(DC)) begin
                    m_level   = ~m_level;
                    m_run     = 0;
                    m_pending = m_level;
                end
            end else begin
                m_run = 0;
            end
            m_hist1 = m_hist0;
            m_hist0 = button_in;
        end
        exp_q.push_back({m_since < int'(HC),
                         m_since < int'(HC + SG),
                         !(m_since < int'(HC + SG)),
                         m_cause});
    end

    // Monitor: compare the DUT's outputs shortly after each edge / async reset.
    logic [4:0] mon_exp;
    logic [4:0] mon_act;
    always @(posedge clk or posedge reset) begin
        #1;
        total++;
        mon_act = {periph_reset, cpu_reset, sequencer_ready, reset_cause};
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_underflow t=%0t got=%b required=an expectation", $time, mon_act);
        end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL outputs t=%0t got periph=%b cpu=%b ready=%b cause=%b required periph=%b cpu=%b ready=%b cause=%b",
                         $time, mon_act[4], mon_act[3], mon_act[2], mon_act[1:0],
                         mon_exp[4], mon_exp[3], mon_exp[2], mon_exp[1:0]);
            end
        end
    end

    task automatic sw_pulse();
        @(negedge clk);
        sw_reset_req = 1'b1;
        @(negedge clk);
        sw_reset_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset between edges, hold for n edges, release at a falling edge.
    task automatic async_pulse(input int n);
        #2;
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    int btn_left;

    initial begin
        reset        = 1'b0;
        button_in    = 1'b0;
        sw_reset_req = 1'b0;
        #2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Power-on sequence into RUN.
        idle(25);

        // Software request from RUN.
        sw_pulse();
        idle(25);

        // Clean press held 200 cycles: exactly one reset.
        @(negedge clk);
        button_in = 1'b1;
        idle(200);
        button_in = 1'b0;
        idle(30);

        // Bouncing button: 5 high / 3 low, never long enough to be accepted.
        for (int i = 0; i < 8; i++) begin
            button_in = 1'b1;
            idle(5);
            button_in = 1'b0;
            idle(3);
        end
        idle(25);

        // Restart during HOLD.
        sw_pulse();
        idle(10);
        sw_pulse();
        idle(25);

        // Button event and software request on the same edge.
        @(negedge clk);
        button_in = 1'b1;
        idle(10);
        sw_reset_req = 1'b1;
        @(negedge clk);
        sw_reset_req = 1'b0;
        idle(20);
        button_in = 1'b0;
        idle(30);

        // Async reset in the middle of GAP, then full power-on timing again.
        sw_pulse();
        idle(17);
        async_pulse(2);
        idle(25);

        // Randomized traffic: button bursts of random length, sparse software
        // requests, rare async resets.
        btn_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (btn_left == 0) begin
                button_in = 1'($urandom_range(0, 1));
                btn_left  = int'($urandom_range(1, 24));
            end
            btn_left--;
            sw_reset_req = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 599) == 0) begin
                async_pulse(int'($urandom_range(1, 3)));
            end
        end
        sw_reset_req = 1'b0;
        button_in    = 1'b0;
        idle(40);

        // Every pushed expectation must have been consumed.
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reflet_reset_sequencer.md
Name: reflet_reset_sequencer

Overview:
- Consumes the bootstrap reset pulse produced at FPGA start, plus a board push-button and a software reset request.
- Turns these into staged, glitch-free reset outputs for the microcontroller.
- Holds every domain in reset for a minimum time, releases the peripherals first and then the CPU after a gap, and reports the cause of the last reset.
- Sits directly between the power-on pulse generator and every other module's reset input.

Parameters:
- HOLD_CYCLES, 16: cycles both resets stay asserted after a reset event; must be at least 1.
- STAGE_GAP, 4: cycles between periph_reset release and cpu_reset release; must be at least 1.
- DEBOUNCE_CYCLES, 8: consecutive stable synchronized samples needed to accept a new button level; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset. It is driven by the power-on pulse or an external reset.
- button_in  in  1  raw push-button, active-high, asynchronous and bouncy.
- sw_reset_req  in  1  synchronous software request, active-high. Any high cycle is a request.
- periph_reset  out  1  active-high reset for peripherals.
- cpu_reset  out  1  active-high reset for the CPU.
- sequencer_ready  out  1  high when both resets are released.
- reset_cause  out  2  cause of the last reset: 00 power/external, 01 button, 10 software. Value 11 is never driven.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All state is registered.
- While reset is high, these values hold and take effect immediately (asynchronously):
  - periph_reset=1, cpu_reset=1, sequencer_ready=0, reset_cause=00.
  - state=HOLD, counters=0.
  - sync flops=0, debounced button=0, edge-detect register=0.
- Edge numbering: edge 1 is the first posedge with reset low. Power-on is treated as entering HOLD at edge 0.
- States and transitions:
  - HOLD: both resets asserted. The counter increments each edge. Leave for GAP at edge HOLD_CYCLES after entry, so periph_reset falls at that edge.
  - GAP: periph_reset=0, cpu_reset=1. Leave for RUN at edge STAGE_GAP after entering GAP. At that edge cpu_reset falls and sequencer_ready rises.
  - RUN: all resets low, ready high. Stay until a request arrives.
- Button path:
  - button_in passes through a 2-flop synchronizer.
  - The debounce counter counts edges on which the synchronized value differs from the debounced level. It clears on any edge where they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level toggles at that edge.
  - A button event is a 0→1 transition of the debounced level, detected via a registered copy of the level. One press gives exactly one event, however long it is held.
  - The falling edge of the debounced level causes no action.
- Request handling (button event or sw_reset_req=1, in any state):
  - Effective at the edge where the request is sampled: state=HOLD, counters cleared, both resets=1, ready=0.
  - A request during HOLD restarts the hold count. A request during GAP re-asserts periph_reset.
  - reset_cause updates at the same edge: 01 for a button event, 10 for a software request.
  - If both arrive on the same edge, the button wins (cause=01).
  - reset_cause holds its value otherwise, including through RUN.
- Outputs never glitch. They come directly from flops or from a state decode of flops.
- Counter widths: $clog2 of the largest count + 1. No wrap can occur, because counters stop at their terminal value.
- Async reset mid-sequence: immediately returns to the reset values; the sequence restarts from edge 1 after release.

Test Plan:
- Power-on (defaults): reset high 3 cycles, then low → periph_reset falls at edge 16, cpu_reset and ready change at edge 20, reset_cause=00.
- Software request: in RUN, sw_reset_req=1 for 1 cycle sampled at edge k → both resets=1 and ready=0 at edge k; periph_reset falls at k+16, cpu_reset at k+20; cause=10.
- Clean button press: in RUN, button_in rises before edge j and stays high → debounced level rises at edge j+9, resets assert at edge j+10, cause=01. Holding the button 200 cycles causes no second reset.
- Bounce rejection: button_in pulses high 5 cycles, low 3 cycles, repeatedly for 60 cycles → no reset, ready stays 1, cause unchanged.
- Restart and priority: sw_reset_req at HOLD count 10 → periph_reset stays high 16 further edges. A button event and sw_reset_req on the same edge → cause=01.
- Async reset mid-GAP: assert reset between edges (not on an edge) → periph_reset=1 and cause=00 before the next edge; after release the power-on timing repeats exactly.
